// File: rtl/cache_plru_update.sv
// cache_plru_update: 8-way tree pseudo-LRU replacement stage. It promotes the hit way on a hit.
// On a miss it picks an invalid way or the PLRU victim and promotes that way.
module cache_plru_update #(
    parameter int WAYS     = 8,
    parameter int WAYS_REP = 3,
    parameter int INDEX    = 3
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                clear,
    input  logic                req_valid,
    input  logic                req_hit,
    input  logic [WAYS_REP-1:0] req_way,
    input  logic [INDEX-1:0]    req_index,
    input  logic [WAYS-1:0]     invalid_mask,
    output logic                resp_valid,
    output logic [WAYS_REP-1:0] victim_way,
    output logic                victim_invalid,
    output logic [6:0]          plru_bits
);
    logic [6:0]          plru [2**INDEX];
    logic [6:0]          cur, nxt;
    logic [WAYS_REP-1:0] walk, first_inv, sel;
    logic [2:0]          walk_leaf, sel_leaf;
    logic                inv;

    always_comb begin
        cur       = plru[req_index];
        walk[2]   = cur[0];
        walk[1]   = walk[2] ? cur[2] : cur[1];
        walk_leaf = 3'd3 + {1'b0, walk[2:1]};
        walk[0]   = cur[walk_leaf];
        first_inv = '0;
        for (int i = WAYS - 1; i >= 0; i--)
            if (invalid_mask[i]) first_inv = i[WAYS_REP-1:0];
        inv      = !req_hit && |invalid_mask;
        sel      = req_hit ? req_way : inv ? first_inv : walk;
        sel_leaf = 3'd3 + {1'b0, sel[2:1]};
        nxt      = cur;
        nxt[0]   = ~sel[2];
        nxt[sel[2] ? 3'd2 : 3'd1] = ~sel[1];
        nxt[sel_leaf] = ~sel[0];
    end

    // Clear outranks a request; a dropped request produces no response.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            for (int i = 0; i < 2**INDEX; i++) plru[i] <= '0;
            resp_valid     <= 1'b0;
            victim_way     <= '0;
            victim_invalid <= 1'b0;
            plru_bits      <= '0;
        end else if (clear) begin
            for (int i = 0; i < 2**INDEX; i++) plru[i] <= '0;
            resp_valid <= 1'b0;
        end else begin
            resp_valid <= req_valid;
            if (req_valid) begin
                plru[req_index] <= nxt;
                victim_way      <= sel;
                victim_invalid  <= inv;
                plru_bits       <= nxt;
            end
        end
    end
endmodule

// File: tb/tb_cache_plru_update.sv
// tb_cache_plru_update: directed and random requests against a heap-walk PLRU model;
// a negedge monitor checks each response against a scoreboard queue.
module tb_cache_plru_update;
    logic       clk = 0, rstb = 0, clear = 0, req_valid = 0, req_hit = 0;
    logic [2:0] req_way = 0, req_index = 0;
    logic [7:0] invalid_mask = 0;
    logic       resp_valid, victim_invalid;
    logic [2:0] victim_way;
    logic [6:0] plru_bits;

    typedef struct packed {
        logic [2:0] way;
        logic       inv;
        logic [6:0] bits;
    } exp_t;

    exp_t q[$];
    bit   t[8][7];
    int   n_vec = 0, n_err = 0;

    cache_plru_update dut (
        .clk(clk), .rstb(rstb), .clear(clear), .req_valid(req_valid), .req_hit(req_hit),
        .req_way(req_way), .req_index(req_index), .invalid_mask(invalid_mask),
        .resp_valid(resp_valid), .victim_way(victim_way), .victim_invalid(victim_invalid),
        .plru_bits(plru_bits)
    );

    always #5 clk = ~clk;

    function automatic void model_reset();
        foreach (t[s, n]) t[s][n] = 0;
    endfunction

    // Tree kept as a heap: node n has children 2n+1 (lower half) and 2n+2 (upper half).
    function automatic void model_access(logic h, logic [2:0] w, logic [2:0] idx, logic [7:0] m);
        int   sel = 0, node = 0, b;
        exp_t e;
        e.inv = 0;
        if (h) sel = w;
        else if (m != 0) begin
            for (int k = 7; k >= 0; k--) if (m[k]) sel = k;
            e.inv = 1;
        end else
            for (int l = 0; l < 3; l++) begin
                b    = t[idx][node];
                sel  = sel * 2 + b;
                node = 2 * node + 1 + b;
            end
        node = 0;
        for (int l = 2; l >= 0; l--) begin
            b = (sel >> l) & 1;
            t[idx][node] = (b == 0);
            node = 2 * node + 1 + b;
        end
        e.way = sel[2:0];
        for (int n = 0; n < 7; n++) e.bits[n] = t[idx][n];
        q.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic issue(input logic c, input logic v, input logic h, input logic [2:0] w,
                         input logic [2:0] idx, input logic [7:0] m);
        clear = c; req_valid = v; req_hit = h; req_way = w; req_index = idx; invalid_mask = m;
        if (c) model_reset();
        else if (v) model_access(h, w, idx, m);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        clear = 0; req_valid = 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        clear = 0; req_valid = 0; rstb = 0;
        q.delete();
        model_reset();
        @(negedge clk);
        rstb = 1;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rstb && resp_valid) begin
            n_vec++;
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL resp: unexpected resp_valid way=%0d inv=%0b bits=%02h",
                         victim_way, victim_invalid, plru_bits);
            end else begin
                exp_t e;
                e = q.pop_front();
                if ({victim_way, victim_invalid, plru_bits} !== e) begin
                    n_err++;
                    $display("FAIL resp: got way=%0d inv=%0b bits=%02h expected way=%0d inv=%0b bits=%02h",
                             victim_way, victim_invalid, plru_bits, e.way, e.inv, e.bits);
                end
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_victim_way", victim_way, 0);
        check("rst_victim_invalid", victim_invalid, 0);
        check("rst_plru_bits", plru_bits, 0);
        rstb = 1;
        @(negedge clk);
        // first miss after reset, then a full victim rotation plus wrap
        issue(0, 1, 0, 0, 0, 0);
        idle(1);
        do_reset();
        repeat (9) issue(0, 1, 0, 0, 0, 0);
        idle(1);
        // hit promotion then miss on a fresh set
        issue(0, 1, 1, 5, 1, 0);
        issue(0, 1, 0, 0, 1, 0);
        // invalid way preferred on miss; hit ignores the mask
        issue(0, 1, 0, 0, 2, 8'b0010_0100);
        issue(0, 1, 1, 3, 2, 8'b0010_0100);
        idle(1);
        // clear together with a request drops the request
        issue(0, 1, 0, 0, 0, 0);
        issue(1, 1, 0, 0, 0, 0);
        check("clear_drop", resp_valid, 0);
        issue(0, 1, 0, 0, 0, 0);
        idle(1);
        // asynchronous reset during the response cycle
        issue(0, 1, 0, 0, 4, 0);
        issue(0, 1, 0, 0, 4, 0);
        req_valid = 0;
        #1 rstb = 0;
        #1 check("async_rst_valid", resp_valid, 0);
        check("async_rst_bits", plru_bits, 0);
        q.delete();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstb = 1;
        @(negedge clk);
        issue(0, 1, 0, 0, 4, 0);
        issue(0, 1, 0, 0, 3, 0);
        idle(2);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [7:0] m;
            m = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'h00;
            issue(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  1'($urandom), 3'($urandom), 3'($urandom), m);
        end
        idle(3);
        check("drain", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
